// File: rtl/mipi_csi_packet_rx.sv
// Single-lane CSI-2 packet decoder: splits each HS burst into header, payload
// and CRC, and emits sync pulses, a payload byte stream and error flags.
module mipi_csi_packet_rx #(
   parameter bit CHECK_CRC = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [7:0]  data,
   output logic        frame_start,
   output logic        frame_end,
   output logic        line_start,
   output logic        line_end,
   output logic        hdr_valid,
   output logic [5:0]  data_type,
   output logic [1:0]  virtual_channel,
   output logic [15:0] word_count,
   output logic        pix_valid,
   output logic [7:0]  pix_data,
   output logic        pix_last,
   output logic        pkt_done,
   output logic        crc_err,
   output logic        trunc_err
);

   typedef enum logic [1:0] {WAIT_LP, HDR, PAYLOAD, CRC} state_t;

   state_t      state;
   logic [1:0]  byte_cnt;   // header byte index, reused as CRC byte index
   logic [7:0]  di_q;
   logic [7:0]  wcl_q;
   logic [7:0]  wch_q;
   logic [15:0] pay_cnt;
   logic [15:0] crc;
   logic [7:0]  crc_lo;

   // CRC-16, reflected poly 0x8408, one byte LSB first
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      return r;
   endfunction

   // Packet parser FSM; every output is a register, pulses default low each cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= WAIT_LP;
         byte_cnt        <= 2'd0;
         di_q            <= 8'h00;
         wcl_q           <= 8'h00;
         wch_q           <= 8'h00;
         pay_cnt         <= 16'h0000;
         crc             <= 16'hFFFF;
         crc_lo          <= 8'h00;
         frame_start     <= 1'b0;
         frame_end       <= 1'b0;
         line_start      <= 1'b0;
         line_end        <= 1'b0;
         hdr_valid       <= 1'b0;
         data_type       <= 6'h00;
         virtual_channel <= 2'd0;
         word_count      <= 16'h0000;
         pix_valid       <= 1'b0;
         pix_data        <= 8'h00;
         pix_last        <= 1'b0;
         pkt_done        <= 1'b0;
         crc_err         <= 1'b0;
         trunc_err       <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         line_start  <= 1'b0;
         line_end    <= 1'b0;
         hdr_valid   <= 1'b0;
         pix_valid   <= 1'b0;
         pix_last    <= 1'b0;
         pkt_done    <= 1'b0;
         crc_err     <= 1'b0;
         trunc_err   <= 1'b0;

         case (state)
            // Discard the rest of a burst; LP marks the start of the next one
            WAIT_LP: begin
               if (!we) begin
                  state    <= HDR;
                  byte_cnt <= 2'd0;
               end
            end

            // DI, WC_L, WC_H, ECC; the ECC byte is not checked
            HDR: begin
               if (we) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: di_q  <= data;
                     2'd1: wcl_q <= data;
                     2'd2: wch_q <= data;
                     2'd3: begin
                        hdr_valid       <= 1'b1;
                        data_type       <= di_q[5:0];
                        virtual_channel <= di_q[7:6];
                        word_count      <= {wch_q, wcl_q};
                        crc             <= 16'hFFFF;
                        byte_cnt        <= 2'd0;
                        if (di_q[5:4] == 2'b00) begin
                           // short packet: sync codes live in DT 0x00..0x03
                           if (di_q[5:2] == 4'h0) begin
                              case (di_q[1:0])
                                 2'd0: frame_start <= 1'b1;
                                 2'd1: frame_end   <= 1'b1;
                                 2'd2: line_start  <= 1'b1;
                                 2'd3: line_end    <= 1'b1;
                              endcase
                           end
                           state <= WAIT_LP;
                        end else if ({wch_q, wcl_q} != 16'h0000) begin
                           pay_cnt <= {wch_q, wcl_q};
                           state   <= PAYLOAD;
                        end else begin
                           state <= CRC;
                        end
                     end
                  endcase
               end else if (byte_cnt != 2'd0) begin
                  // burst ended inside the header
                  trunc_err <= 1'b1;
                  byte_cnt  <= 2'd0;
               end
            end

            // Stream payload and fold it into the running CRC
            PAYLOAD: begin
               if (we) begin
                  pix_valid <= 1'b1;
                  pix_data  <= data;
                  crc       <= crc_byte(crc, data);
                  if (pay_cnt == 16'h0001) begin
                     pix_last <= 1'b1;
                     byte_cnt <= 2'd0;
                     state    <= CRC;
                  end else begin
                     pay_cnt <= pay_cnt - 16'h0001;
                  end
               end else begin
                  trunc_err <= 1'b1;
                  byte_cnt  <= 2'd0;
                  state     <= HDR;
               end
            end

            // CRC_L then CRC_H; trailing bytes are dropped in WAIT_LP
            CRC: begin
               if (we) begin
                  if (byte_cnt == 2'd0) begin
                     crc_lo   <= data;
                     byte_cnt <= 2'd1;
                  end else begin
                     pkt_done <= 1'b1;
                     crc_err  <= CHECK_CRC && ({data, crc_lo} != crc);
                     byte_cnt <= 2'd0;
                     state    <= WAIT_LP;
                  end
               end else begin
                  trunc_err <= 1'b1;
                  byte_cnt  <= 2'd0;
                  state     <= HDR;
               end
            end

            default: state <= WAIT_LP;
         endcase
      end
   end

endmodule

// File: tb/tb_mipi_csi_packet_rx.sv
// Bench for mipi_csi_packet_rx: packet-level model builds expected per-cycle
// outputs; a second instance with CHECK_CRC=0 must never flag crc_err.
module tb_mipi_csi_packet_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [7:0]  data = 8'h00;

   logic        frame_start, frame_end, line_start, line_end, hdr_valid;
   logic [5:0]  data_type;
   logic [1:0]  virtual_channel;
   logic [15:0] word_count;
   logic        pix_valid, pix_last, pkt_done, crc_err, trunc_err;
   logic [7:0]  pix_data;

   logic        frame_start_0, frame_end_0, line_start_0, line_end_0, hdr_valid_0;
   logic [5:0]  data_type_0;
   logic [1:0]  virtual_channel_0;
   logic [15:0] word_count_0;
   logic        pix_valid_0, pix_last_0, pkt_done_0, crc_err_0, trunc_err_0;
   logic [7:0]  pix_data_0;

   mipi_csi_packet_rx #(.CHECK_CRC(1'b1)) dut (
      .clk(clk), .reset(reset), .we(we), .data(data),
      .frame_start(frame_start), .frame_end(frame_end),
      .line_start(line_start), .line_end(line_end), .hdr_valid(hdr_valid),
      .data_type(data_type), .virtual_channel(virtual_channel), .word_count(word_count),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
      .pkt_done(pkt_done), .crc_err(crc_err), .trunc_err(trunc_err));

   mipi_csi_packet_rx #(.CHECK_CRC(1'b0)) dut0 (
      .clk(clk), .reset(reset), .we(we), .data(data),
      .frame_start(frame_start_0), .frame_end(frame_end_0),
      .line_start(line_start_0), .line_end(line_end_0), .hdr_valid(hdr_valid_0),
      .data_type(data_type_0), .virtual_channel(virtual_channel_0), .word_count(word_count_0),
      .pix_valid(pix_valid_0), .pix_data(pix_data_0), .pix_last(pix_last_0),
      .pkt_done(pkt_done_0), .crc_err(crc_err_0), .trunc_err(trunc_err_0));

   always #5 clk = ~clk;

   typedef struct packed {
      logic fs, fe, ls, le, hv, pv, pl, pd, ce, ce0, te;
      logic [7:0]  pd8;
      logic [5:0]  dt;
      logic [1:0]  vc;
      logic [15:0] wc;
   } obs_t;

   logic       st_we[$];
   logic [7:0] st_d[$];
   obs_t       exp_q[$];
   obs_t       obs_q[$];

   // model's view of the held header fields
   logic [5:0]  m_dt = 6'h00;
   logic [1:0]  m_vc = 2'd0;
   logic [15:0] m_wc = 16'h0000;

   int checks = 0;
   int failures = 0;

   function automatic obs_t sample();
      obs_t o;
      o     = '0;
      o.fs  = frame_start;  o.fe = frame_end;  o.ls = line_start;  o.le = line_end;
      o.hv  = hdr_valid;    o.pv = pix_valid;  o.pl = pix_last;    o.pd = pkt_done;
      o.ce  = crc_err;      o.ce0 = crc_err_0; o.te = trunc_err;
      o.pd8 = pix_valid ? pix_data : 8'h00;
      o.dt  = data_type;    o.vc = virtual_channel; o.wc = word_count;
      return o;
   endfunction

   function automatic obs_t idle();
      obs_t e;
      e    = '0;
      e.dt = m_dt; e.vc = m_vc; e.wc = m_wc;
      return e;
   endfunction

   function automatic logic [15:0] crc16(input logic [7:0] p[$]);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (p[i]) begin
         c ^= {8'h00, p[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
      return c;
   endfunction

   task automatic push(input logic w, input logic [7:0] d, input obs_t e);
      st_we.push_back(w); st_d.push_back(d); exp_q.push_back(e);
   endtask

   task automatic add_gap(input int n);
      repeat (n) push(1'b0, 8'($urandom), idle());
   endtask

   // One burst plus the LP cycle that follows it. keep<0 sends the whole burst,
   // otherwise only the first keep bytes. fixed>=0 forces every payload byte.
   task automatic add_packet(input logic [7:0] di, input logic [15:0] wc, input bit bad_crc,
                             input int keep, input int trail, input int fixed);
      logic [7:0]  b[$];
      logic [7:0]  pay[$];
      logic [15:0] c;
      obs_t        e;
      bit          long_p;
      int          need;
      long_p = (di[5:0] >= 6'h10);
      b = {di, wc[7:0], wc[15:8], 8'($urandom)};
      if (long_p) begin
         for (int i = 0; i < int'(wc); i++) begin
            pay.push_back(fixed >= 0 ? 8'(fixed) : 8'($urandom));
            b.push_back(pay[i]);
         end
         c = crc16(pay);
         if (bad_crc) c ^= 16'(1 << $urandom_range(15, 0));
         b.push_back(c[7:0]);
         b.push_back(c[15:8]);
      end
      need = b.size();
      for (int i = 0; i < trail; i++) b.push_back(8'($urandom));
      if (keep >= 0 && keep < b.size()) b = b[0:keep-1];
      for (int k = 0; k < b.size(); k++) begin
         e = idle();
         if (k == 3) begin
            m_dt = di[5:0]; m_vc = di[7:6]; m_wc = wc;
            e = idle();
            e.hv = 1'b1;
            case (di[5:0])
               6'h00: e.fs = 1'b1;
               6'h01: e.fe = 1'b1;
               6'h02: e.ls = 1'b1;
               6'h03: e.le = 1'b1;
               default: ;
            endcase
         end else if (long_p && k >= 4 && k < 4 + int'(wc)) begin
            e.pv  = 1'b1;
            e.pd8 = b[k];
            e.pl  = (k == 3 + int'(wc));
         end else if (long_p && k == need - 1) begin
            e.pd = 1'b1;
            e.ce = bad_crc;
         end
         push(1'b1, b[k], e);
      end
      e = idle();
      e.te = (b.size() < need);
      push(1'b0, 8'($urandom), e);
   endtask

   task automatic run_seq();
      obs_q.delete();
      for (int i = 0; i < st_we.size(); i++) begin
         we = st_we[i]; data = st_d[i];
         @(posedge clk); #1;
         obs_q.push_back(sample());
      end
      st_we.delete(); st_d.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; we = 1'b1; data = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sample() !== obs_t'('0) || pix_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_state got %h pix_data %h exp 0", sample(), pix_data);
      end
      we = 1'b0;
      reset = 1'b0;
      m_dt = '0; m_vc = '0; m_wc = '0;
   endtask

   task automatic test_short_fs();
      add_gap(1);
      add_packet(8'h00, 16'h0001, 1'b0, -1, 0, -1);
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL short_fs cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_long_crc();
      add_packet(8'h2A, 16'h0001, 1'b0, -1, 0, 0);   // payload 0x00, CRC 0x0F87
      add_packet(8'h2A, 16'h0001, 1'b1, -1, 0, 0);   // corrupted CRC
      add_packet(8'h6E, 16'h0007, 1'b1, -1, 1, -1);
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL long_crc cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_wc0();
      add_packet(8'h12, 16'h0000, 1'b0, -1, 3, -1);
      add_packet(8'h92, 16'h0000, 1'b1, -1, 0, -1);
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL wc0 cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_trunc();
      add_packet(8'h24, 16'h0004, 1'b0, 6, 0, -1);   // drop after 2 payload bytes
      add_packet(8'h01, 16'h1234, 1'b0, -1, 0, -1);  // FE
      add_packet(8'h2B, 16'h0003, 1'b0, 2, 0, -1);   // drop inside header
      add_packet(8'h2B, 16'h0003, 1'b0, 8, 0, -1);   // drop between CRC bytes
      add_packet(8'h43, 16'h0002, 1'b0, -1, 0, -1);
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL trunc cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0]  di;
      logic [15:0] wc;
      int          need, keep, r;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 3);
         if (r == 0)      di = {2'($urandom), 6'($urandom_range(0, 3))};
         else if (r == 1) di = {2'($urandom), 6'($urandom_range(4, 15))};
         else             di = {2'($urandom), 6'($urandom_range(16, 63))};
         if (di[5:0] >= 6'h10) begin
            wc = 16'($urandom_range(0, 12));
            need = 6 + int'(wc);
         end else begin
            wc = 16'($urandom);
            need = 4;
         end
         keep = ($urandom_range(0, 4) == 0) ? $urandom_range(1, need - 1) : -1;
         add_packet(di, wc, ($urandom_range(0, 3) == 0), keep, $urandom_range(0, 2), -1);
         if ($urandom_range(0, 2) == 0) add_gap($urandom_range(1, 3));
      end
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL back_to_back cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_max_wc();
      add_packet(8'h2B, 16'hFFFF, 1'b0, -1, 0, -1);
      add_packet(8'h03, 16'h0000, 1'b0, -1, 0, -1);
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL max_wc cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      add_packet(8'h2C, 16'h0008, 1'b0, 7, 0, -1);
      void'(st_we.pop_back()); void'(st_d.pop_back()); void'(exp_q.pop_back());
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL pre_reset cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (sample() !== obs_t'('0) || pix_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid got %h pix_data %h exp 0", sample(), pix_data);
      end
      m_dt = '0; m_vc = '0; m_wc = '0;
      we = 1'b1; data = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      // remainder of the old burst plus a fake header must be ignored
      repeat (6) push(1'b1, 8'($urandom_range(0, 3)), idle());
      add_gap(1);
      add_packet(8'h02, 16'h00AB, 1'b0, -1, 0, -1);
      add_packet(8'h1E, 16'h0005, 1'b0, -1, 0, -1);
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL post_reset cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   initial begin
      #5_000_000;
      failures++;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_short_fs();
      test_long_crc();
      test_wc0();
      test_trunc();
      test_back_to_back();
      test_max_wc();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
